// File: rtl/lsu_bus_pkg.sv
// Shared types and defaults for the LSU bus router: FSM states, default region map, region ids.
package lsu_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StErr
  } router_state_e;

  localparam int unsigned RGN_DMEM   = 0;
  localparam int unsigned RGN_OUT_IO = 1;
  localparam int unsigned RGN_IN_IO  = 2;

  // Region 0 in the LSBs.
  localparam logic [95:0] DEFAULT_REGION_BASE = {32'h1001_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [95:0] DEFAULT_REGION_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000};

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_region_decoder.sv
// Combinational base/mask region match; the lowest matching index wins on overlap.
module addr_region_decoder
  import lsu_bus_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK,
  parameter int unsigned IDX_W = idx_width(NUM_REGIONS)
) (
  input  logic [ADDR_W-1:0]      addr_i,
  output logic [NUM_REGIONS-1:0] hit_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   miss_o
);

  // Scan from the top down so a lower-indexed match overwrites a higher one.
  always_comb begin
    hit_o  = '0;
    idx_o  = '0;
    miss_o = 1'b1;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if ((addr_i & REGION_MASK[k*ADDR_W +: ADDR_W]) == REGION_BASE[k*ADDR_W +: ADDR_W]) begin
        hit_o    = '0;
        hit_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
        miss_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lsu_bus_router.sv
// Single-outstanding LSU request router with base/mask decode and error responses.
// Optional device timeout compiled in with LSU_ROUTER_TIMEOUT_EN.
module lsu_bus_router
  import lsu_bus_pkg::*;
#(
  parameter int unsigned NUM_REGIONS    = 3,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic                          i_req_wren,
  input  logic [DATA_W-1:0]             i_req_wdata,
  input  logic [DATA_W/8-1:0]           i_req_bmask,
  output logic                          o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [NUM_REGIONS-1:0]        o_dev_valid,
  input  logic [NUM_REGIONS-1:0]        i_dev_ready,
  output logic [ADDR_W-1:0]             o_dev_addr,
  output logic                          o_dev_wren,
  output logic [DATA_W-1:0]             o_dev_wdata,
  output logic [DATA_W/8-1:0]           o_dev_bmask,
  input  logic [NUM_REGIONS-1:0]        i_dev_rsp_valid,
  input  logic [NUM_REGIONS*DATA_W-1:0] i_dev_rdata,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REGIONS);
  localparam int unsigned BM_W  = DATA_W / 8;

  router_state_e state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   wren_q, wren_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [BM_W-1:0]        bmask_q, bmask_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [NUM_REGIONS-1:0] hit_q, hit_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [NUM_REGIONS-1:0] dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_miss;

  logic                   dev_ready_sel;
  logic                   dev_rsp_sel;
  logic [DATA_W-1:0]      dev_rdata_sel;
  logic                   timeout_hit;

  addr_region_decoder #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .addr_i (i_req_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx),
    .miss_o (dec_miss)
  );

  // Only the latched region's handshake bits are ever looked at.
  always_comb begin
    dev_ready_sel = 1'b0;
    dev_rsp_sel   = 1'b0;
    dev_rdata_sel = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (sel_q == IDX_W'(k)) begin
        dev_ready_sel = i_dev_ready[k];
        dev_rsp_sel   = i_dev_rsp_valid[k];
        dev_rdata_sel = i_dev_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef LSU_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle, so it is zero on every entry to ISSUE.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StIssue || state_q == StWait) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wren_d  = wren_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    sel_d   = sel_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          wren_d  = i_req_wren;
          wdata_d = i_req_wdata;
          bmask_d = i_req_bmask;
          sel_d   = dec_idx;
          hit_d   = dec_hit;
          state_d = dec_miss ? StErr : StIssue;
        end
      end
      StIssue: begin
        if (dev_ready_sel) begin
          if (dev_rsp_sel) begin
            rdata_d = dev_rdata_sel;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StWait: begin
        if (dev_rsp_sel) begin
          rdata_d = dev_rdata_sel;
          state_d = StResp;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      bmask_q <= '0;
      sel_q   <= '0;
      hit_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      sel_q   <= sel_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_req_ready = (state_q == StIdle);
  assign o_busy      = (state_q != StIdle);
  assign o_dev_valid = (state_q == StIssue) ? hit_q : '0;
  assign o_dev_addr  = addr_q;
  assign o_dev_wren  = wren_q;
  assign o_dev_wdata = wdata_q;
  assign o_dev_bmask = bmask_q;
  assign o_rsp_valid = (state_q == StResp) || (state_q == StErr);
  assign o_rsp_err   = (state_q == StErr);
  assign o_rsp_rdata = (state_q == StResp && !wren_q) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_bus_router.sv
// Scoreboard bench for lsu_bus_router: expected responses queued at stimulus, checked on output.
module tb_lsu_bus_router;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wren;
  logic [31:0] req_wdata;
  logic [3:0]  req_bmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  dev_valid;
  logic [2:0]  dev_ready;
  logic [31:0] dev_addr;
  logic        dev_wren;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_bmask;
  logic [2:0]  dev_rsp;
  logic [95:0] dev_rdata;
  logic        busy;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         rsp_count = 0;
  logic [2:0] seen_dev = '0;

  lsu_bus_router #(
    .NUM_REGIONS    (3),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_addr      (req_addr),
    .i_req_wren      (req_wren),
    .i_req_wdata     (req_wdata),
    .i_req_bmask     (req_bmask),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_rdata     (rsp_rdata),
    .o_rsp_err       (rsp_err),
    .o_dev_valid     (dev_valid),
    .i_dev_ready     (dev_ready),
    .o_dev_addr      (dev_addr),
    .o_dev_wren      (dev_wren),
    .o_dev_wdata     (dev_wdata),
    .o_dev_bmask     (dev_bmask),
    .i_dev_rsp_valid (dev_rsp),
    .i_dev_rdata     (dev_rdata),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    seen_dev = seen_dev | dev_valid;
    if (rsp_valid) begin
      rsp_t e;
      rsp_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response",
                 rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
          failures++;
          $display("FAIL rsp_payload: got rdata=%h err=%b, required rdata=%h err=%b",
                   rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wren  = 1'b0;
    req_wdata = 32'h0;
    req_bmask = 4'h0;
    dev_ready = 3'b000;
    dev_rsp   = 3'b000;
    dev_rdata = '0;
    #3;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, busy} !== 35'h0) begin
      failures++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h busy=%b, required all 0",
               rsp_valid, rsp_err, rsp_rdata, busy);
    end
    checks++;
    if ({dev_valid, dev_addr, dev_wren, dev_wdata, dev_bmask} !== 72'h0) begin
      failures++;
      $display("FAIL reset_dev: got valid=%b addr=%h wren=%b wdata=%h bmask=%h, required 0",
               dev_valid, dev_addr, dev_wren, dev_wdata, dev_bmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    @(negedge clk);
    seen_dev  = '0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    req_wren  = 1'b0;
    req_wdata = 32'h55AA_55AA;
    req_bmask = 4'hF;
    dev_rdata = {32'hBAD2_BAD2, 32'hBAD1_BAD1, 32'h0};
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (dev_valid !== 3'b001) begin
      failures++; $display("FAIL read_strobe: got %b, required 001", dev_valid);
    end
    checks++;
    if (dev_addr !== 32'h0000_0100 || dev_wren !== 1'b0) begin
      failures++;
      $display("FAIL read_payload: got addr=%h wren=%b, required 00000100/0", dev_addr, dev_wren);
    end
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL read_busy: got ready=%b busy=%b, required 0/1", req_ready, busy);
    end
    dev_ready = 3'b001;
    dev_rsp   = 3'b010;
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    @(negedge clk);
    checks++;
    if (dev_valid !== 3'b000) begin
      failures++; $display("FAIL read_wait_strobe: got %b, required 000", dev_valid);
    end
    dev_ready = 3'b000;
    dev_rsp   = 3'b001;
    dev_rdata[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    dev_rsp = 3'b000;
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL read_latency: got %0d pending, required 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (seen_dev !== 3'b001 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_only_dev0: got seen=%b ready=%b, required 001/1", seen_dev, req_ready);
    end
  endtask

  task automatic test_write;
    @(negedge clk);
    seen_dev  = '0;
    req_valid = 1'b1;
    req_addr  = 32'h1000_0004;
    req_wren  = 1'b1;
    req_wdata = 32'h0000_00FF;
    req_bmask = 4'b0001;
    dev_rdata = {32'h0, 32'h1234_5678, 32'h0};
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (dev_valid !== 3'b010) begin
      failures++; $display("FAIL write_strobe: got %b, required 010", dev_valid);
    end
    checks++;
    if ({dev_addr, dev_wren, dev_wdata, dev_bmask} !== {32'h1000_0004, 1'b1, 32'hFF, 4'b0001})
    begin
      failures++;
      $display("FAIL write_payload: got addr=%h wren=%b wdata=%h bmask=%b, required 10000004/1/ff/0001",
               dev_addr, dev_wren, dev_wdata, dev_bmask);
    end
    dev_ready = 3'b010;
    dev_rsp   = 3'b010;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    dev_ready = 3'b000;
    dev_rsp   = 3'b000;
    #1;
    checks++;
    if (exp_q.size() != 0 || seen_dev !== 3'b010) begin
      failures++;
      $display("FAIL write_ack: got pending=%0d seen=%b, required 0/010", exp_q.size(), seen_dev);
    end
  endtask

  task automatic test_unmapped;
    @(negedge clk);
    seen_dev  = '0;
    req_valid = 1'b1;
    req_addr  = 32'h2000_0000;
    req_wren  = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL unmapped_latency: got %0d pending, required 0", exp_q.size());
    end
    checks++;
    if (req_ready !== 1'b0 || dev_valid !== 3'b000) begin
      failures++;
      $display("FAIL unmapped_err_cycle: got ready=%b strobe=%b, required 0/000", req_ready,
               dev_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || seen_dev !== 3'b000) begin
      failures++;
      $display("FAIL unmapped_after: got ready=%b rsp=%b seen=%b, required 1/0/000", req_ready,
               rsp_valid, seen_dev);
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    seen_dev  = '0;
    req_valid = 1'b1;
    req_addr  = 32'h1001_0020;
    req_wren  = 1'b0;
    req_wdata = 32'h0;
    req_bmask = 4'hF;
    @(negedge clk);
    // A competing request stays asserted for the whole transaction.
    req_addr = 32'h0000_0040;
    req_wren = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dev_valid !== 3'b100) begin
        failures++; $display("FAIL stall_strobe[%0d]: got %b, required 100", i, dev_valid);
      end
      checks++;
      if (dev_addr !== 32'h1001_0020 || dev_wren !== 1'b0) begin
        failures++;
        $display("FAIL stall_payload[%0d]: got addr=%h wren=%b, required 10010020/0", i,
                 dev_addr, dev_wren);
      end
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_busy[%0d]: got ready=%b busy=%b, required 0/1", i, req_ready, busy);
      end
      if (i == 5) begin
        dev_ready = 3'b100;
        exp_q.push_back('{rdata: 32'hCAFE_0002, err: 1'b0});
      end
      @(negedge clk);
    end
    dev_ready = 3'b000;
    dev_rsp   = 3'b100;
    dev_rdata = {32'hCAFE_0002, 32'h0, 32'hFFFF_FFFF};
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_wait_busy: got ready=%b busy=%b, required 0/1", req_ready, busy);
    end
    @(negedge clk);
    req_valid = 1'b0;
    dev_rsp   = 3'b000;
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL stall_rsp: got %0d pending, required 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (seen_dev !== 3'b100 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_second_req: got seen=%b busy=%b, required 100/0", seen_dev, busy);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h2000_0010;
    req_wren  = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    exp_q.push_back('{rdata: 32'h1357_9BDF, err: 1'b0});
    @(negedge clk);
    req_addr = 32'h0000_7FFC;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready: got %b, required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (dev_valid !== 3'b001 || dev_addr !== 32'h0000_7FFC) begin
      failures++;
      $display("FAIL b2b_issue: got strobe=%b addr=%h, required 001/00007ffc", dev_valid,
               dev_addr);
    end
    dev_ready = 3'b001;
    dev_rsp   = 3'b001;
    dev_rdata = {32'h0, 32'h0, 32'h1357_9BDF};
    @(negedge clk);
    dev_ready = 3'b000;
    dev_rsp   = 3'b000;
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_rsp: got %0d pending, required 0", exp_q.size());
    end
  endtask

`ifdef LSU_ROUTER_TIMEOUT_EN
  task automatic test_timeout;
    int err_k;
    int rc;
    err_k = 0;
    rc    = rsp_count;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h1000_0000;
    req_wren  = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (rsp_err && err_k == 0) err_k = k;
      if (k == 20) begin
        dev_ready = 3'b010;
        dev_rsp   = 3'b010;
        dev_rdata = {32'h0, 32'hABCD_0001, 32'h0};
      end
      if (k == 21) begin
        dev_ready = 3'b000;
        dev_rsp   = 3'b000;
      end
    end
    checks++;
    if (err_k != 17) begin
      failures++; $display("FAIL timeout_cycle: got err at %0d, required 17", err_k);
    end
    checks++;
    if (rsp_count - rc != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_late_rsp: got %0d responses, required 1", rsp_count - rc);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int rc;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0200;
    req_wren  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    dev_ready = 3'b001;
    @(negedge clk);
    dev_ready = 3'b000;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_wait: got busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dev_valid, busy, rsp_valid, req_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL rstmid_outputs: got strobe=%b busy=%b rsp=%b ready=%b, required 000/0/0/1",
               dev_valid, busy, rsp_valid, req_ready);
    end
    checks++;
    if ({dev_addr, dev_wren, dev_wdata, dev_bmask, rsp_rdata} !== 101'h0) begin
      failures++;
      $display("FAIL rstmid_payload: got addr=%h rdata=%h, required 0", dev_addr, rsp_rdata);
    end
    rc = rsp_count;
    @(negedge clk);
    rst_n     = 1'b1;
    dev_rsp   = 3'b001;
    dev_rdata = {32'h0, 32'h0, 32'hFFFF_FFFF};
    repeat (3) @(negedge clk);
    dev_rsp = 3'b000;
    @(negedge clk);
    checks++;
    if (rsp_count != rc || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_rsp: got %0d responses busy=%b, required 0/0", rsp_count - rc,
               busy);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_stall();
    test_back_to_back();
`ifdef LSU_ROUTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_bus_router.md
# lsu_bus_router

Parametrised successor to the LSU address decode stage. It accepts one load/store request at a time from the LSU over a valid/ready handshake. It decodes the address against `NUM_REGIONS` base/mask windows, forwards the request to the matching device port, and returns a single-cycle response (read data or write ack) to the LSU. Unmapped addresses get an error response. With the timeout option compiled in, unresponsive devices also get an error response. It sits between the LSU and DMEM/output-I/O/input-I/O, replacing flag-only decoding with a sequenced, single-outstanding transaction.

## Interface
- `NUM_REGIONS`, 3, number of decoded windows/device ports
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8)
- `REGION_BASE`, {32'h1001_0000, 32'h1000_0000, 32'h0000_0000}, packed `NUM_REGIONS*ADDR_W`, region 0 in LSBs
- `REGION_MASK`, {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000}, packed, same layout
- `TIMEOUT_CYCLES`, 16, device wait limit (used only with timeout option), ≥2
- `i_clk` in 1 — sole clock, rising edge
- `i_reset` in 1 — asynchronous, active-low
- `i_req_valid` / `o_req_ready` in/out 1 — LSU request handshake
- `i_req_addr` in `ADDR_W`; `i_req_wren` in 1; `i_req_wdata` in `DATA_W`; `i_req_bmask` in `DATA_W/8`
- `o_rsp_valid` out 1; `o_rsp_rdata` out `DATA_W`; `o_rsp_err` out 1
- `o_dev_valid` out `NUM_REGIONS` — one-hot request strobe
- `i_dev_ready` in `NUM_REGIONS`
- `o_dev_addr` out `ADDR_W`; `o_dev_wren` out 1; `o_dev_wdata` out `DATA_W`; `o_dev_bmask` out `DATA_W/8` — shared payload
- `i_dev_rsp_valid` in `NUM_REGIONS`; `i_dev_rdata` in `NUM_REGIONS*DATA_W`, region 0 in LSBs
- `o_busy` out 1 — high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- **IDLE**
  - `o_req_ready`=1.
  - On `i_req_valid`&&`o_req_ready`: latch addr/wren/wdata/bmask into payload registers.
  - Decode: `hit[k] = (addr & MASK[k]) == BASE[k]`. The lowest index wins on overlap; latch the selected index.
  - Any hit → ISSUE. No hit → ERR.
- **ISSUE**
  - `o_dev_valid[sel]`=1 and the payload is held stable.
  - On `i_dev_ready[sel]` → WAIT.
  - If `i_dev_rsp_valid[sel]` is also high in that cycle, capture rdata and go directly to RESP.
- **WAIT**
  - On `i_dev_rsp_valid[sel]`: capture `i_dev_rdata[sel]` → RESP.
- **RESP**
  - `o_rsp_valid`=1 for exactly one cycle, `o_rsp_err`=0.
  - `o_rsp_rdata` = captured data for reads, 0 for writes.
  - → IDLE.
- **ERR**
  - `o_rsp_valid`=1 and `o_rsp_err`=1 for one cycle, `o_rsp_rdata`=0.
  - → IDLE.
  - No device strobe is ever raised for an unmapped address.
- Response has no back-pressure; the LSU must sink it.
- `i_dev_ready`/`i_dev_rsp_valid` bits of non-selected regions are ignored in every state.
- Outside ISSUE, `o_dev_valid`=0. The payload outputs always show the latched registers.
- `o_req_ready`=0 in every state except IDLE: single outstanding transaction.

## Timing
- Reset (async assert):
  - State=IDLE.
  - `o_req_ready`=1; all other outputs 0.
  - Payload registers, selected index and captured data all 0.
- Reset mid-transaction: the transaction is abandoned. `o_dev_valid` drops immediately and no response is issued.
- Unmapped: accept at edge E0 → `o_rsp_err` visible in the cycle after E0. Next accept possible at E2.
- Mapped, zero-wait device (ready in the ISSUE cycle, rsp one cycle later): accept at E0, ready at E1, rsp at E2, `o_rsp_valid` after E2. Accept-to-response minimum is 2 edges when ready and rsp coincide.
- All outputs are register-driven or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- Macro: `LSU_ROUTER_TIMEOUT_EN`.
- Defined:
  - A cycle counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches `TIMEOUT_CYCLES` before completion: drop `o_dev_valid` → ERR (error response).
  - A late `i_dev_rsp_valid` after the timeout is ignored.
- Undefined: no counter; ISSUE/WAIT wait indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- Package `lsu_bus_pkg`:
  - State enum `router_state_e`.
  - Default `REGION_BASE`/`REGION_MASK` constants.
  - Region index constants `RGN_DMEM`=0, `RGN_OUT_IO`=1, `RGN_IN_IO`=2.
- Sub-module `addr_region_decoder`: combinational priority match, parametrised like the top. Outputs a one-hot hit vector, a binary index and a miss flag.

## Test plan
- Read 0x0000_0100, region 0 responds with rdata 0xDEAD_BEEF one cycle after ready → single `o_rsp_valid` with 0xDEAD_BEEF, err=0; only `o_dev_valid[0]` ever pulses.
- Write 0x1000_0004 data 0x0000_00FF bmask 4'b0001 → `o_dev_valid[1]` with matching payload; ack response rdata=0, err=0.
- Access 0x2000_0000 → no device strobe; `o_rsp_err`=1 exactly one cycle after accept; `o_req_ready` high again the following cycle.
- Region 2 holds ready low 5 cycles → payload stable throughout; `o_req_ready`=0 and `o_busy`=1 until RESP. A second `i_req_valid` is not accepted.
- With `LSU_ROUTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, region 1 never responds → error response after 16 cycles; a device rsp at cycle 20 is ignored.
- Assert `i_reset` low while in WAIT → outputs return to reset values immediately; no `o_rsp_valid` after release.
